// File: rtl/pll0_clkgen.sv
// rtl/pll0_clkgen.sv - PLL0 stand-in: reference lock detector plus phase-aligned clock dividers
//
// Samples the reference clock clkin1 in the clk_tb domain, measures its period
// and declares lock after LOCK_CNT consecutive in-tolerance periods. While locked,
// three registered divided clocks of clk_tb are produced with coincident first edges.
//
// Ports:
//   clk_tb    in   system clock, all logic on its rising edge
//   rst_n     in   asynchronous active-low reset
//   grs_n     in   global reset, active-low, combined with rst_n
//   clkin1    in   reference clock, asynchronous to clk_tb
//   clkout0   out  clk_tb / DIV0
//   clkout1   out  clk_tb / DIV1
//   clkout2   out  clk_tb / DIV2
//   pll_lock  out  registered lock indication, qualifies clkout0..2
module pll0_clkgen #(
    parameter int unsigned REF_PERIOD = 10,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned TIMEOUT    = 20,
    parameter int unsigned DIV0       = 4,
    parameter int unsigned DIV1       = 5,
    parameter int unsigned DIV2       = 10
) (
    input  logic clk_tb,
    input  logic rst_n,
    input  logic grs_n,
    input  logic clkin1,
    output logic clkout0,
    output logic clkout1,
    output logic clkout2,
    output logic pll_lock
);

    localparam logic [16:0] MEAS_LO    = 17'(REF_PERIOD - TOL);
    localparam logic [16:0] MEAS_HI    = 17'(REF_PERIOD + TOL);
    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic [15:0] LOCK_CNT_C = 16'(LOCK_CNT);

    localparam logic [7:0] LAST0 = 8'(DIV0 - 1);
    localparam logic [7:0] LAST1 = 8'(DIV1 - 1);
    localparam logic [7:0] LAST2 = 8'(DIV2 - 1);
    // ceil(DIV/2): odd divisors spend the extra cycle high
    localparam logic [7:0] HALF0 = 8'((DIV0 + 1) / 2);
    localparam logic [7:0] HALF1 = 8'((DIV1 + 1) / 2);
    localparam logic [7:0] HALF2 = 8'((DIV2 + 1) / 2);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    // Either reset source clears the whole block asynchronously
    logic arst_n;
    assign arst_n = rst_n & grs_n;

    logic        sync1_q;
    logic        sync2_q;
    logic        sync3_q;
    logic        ref_rise_q;
    logic [15:0] per_cnt_q;
    logic        seen_q;
    logic [15:0] good_cnt_q;
    state_e      state_q;
    logic        lock_q;

    logic [7:0]  cnt0_q;
    logic [7:0]  cnt1_q;
    logic [7:0]  cnt2_q;
    logic        clkout0_q;
    logic        clkout1_q;
    logic        clkout2_q;

    // Measured period is the count since the previous edge plus the edge cycle itself
    logic [16:0] meas;
    logic        meas_valid;
    logic        good_period;

    assign meas        = {1'b0, per_cnt_q} + 17'd1;
    assign meas_valid  = ref_rise_q & seen_q;
    assign good_period = (meas >= MEAS_LO) && (meas <= MEAS_HI);

    always_ff @(posedge clk_tb or negedge arst_n) begin
        if (!arst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            ref_rise_q <= 1'b0;
            per_cnt_q  <= 16'd0;
            seen_q     <= 1'b0;
            good_cnt_q <= 16'd0;
            state_q    <= UNLOCKED;
            lock_q     <= 1'b0;
        end else begin
            sync1_q    <= clkin1;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            ref_rise_q <= sync2_q & ~sync3_q;

            if (ref_rise_q) begin
                per_cnt_q <= 16'd0;
            end else if (per_cnt_q != 16'hFFFF) begin
                per_cnt_q <= per_cnt_q + 16'd1;
            end

            // The first edge only opens a measurement window
            if (ref_rise_q) begin
                seen_q <= 1'b1;
            end

            case (state_q)
                UNLOCKED: begin
                    if (meas_valid) begin
                        if (!good_period) begin
                            good_cnt_q <= 16'd0;
                        end else if (good_cnt_q + 16'd1 == LOCK_CNT_C) begin
                            good_cnt_q <= 16'd0;
                            state_q    <= LOCKED;
                            lock_q     <= 1'b1;
                        end else begin
                            good_cnt_q <= good_cnt_q + 16'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (meas_valid && !good_period) begin
                        good_cnt_q <= 16'd0;
                        state_q    <= UNLOCKED;
                        lock_q     <= 1'b0;
                    end else if (!ref_rise_q && per_cnt_q == TIMEOUT_C) begin
                        // Reference lost: the next edge restarts measurement from scratch
                        good_cnt_q <= 16'd0;
                        seen_q     <= 1'b0;
                        state_q    <= UNLOCKED;
                        lock_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= UNLOCKED;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    // Dividers idle at zero while unlocked so all three start together on lock
    always_ff @(posedge clk_tb or negedge arst_n) begin
        if (!arst_n) begin
            cnt0_q    <= 8'd0;
            cnt1_q    <= 8'd0;
            cnt2_q    <= 8'd0;
            clkout0_q <= 1'b0;
            clkout1_q <= 1'b0;
            clkout2_q <= 1'b0;
        end else if (!lock_q) begin
            cnt0_q    <= 8'd0;
            cnt1_q    <= 8'd0;
            cnt2_q    <= 8'd0;
            clkout0_q <= 1'b0;
            clkout1_q <= 1'b0;
            clkout2_q <= 1'b0;
        end else begin
            clkout0_q <= (cnt0_q < HALF0);
            clkout1_q <= (cnt1_q < HALF1);
            clkout2_q <= (cnt2_q < HALF2);
            cnt0_q    <= (cnt0_q == LAST0) ? 8'd0 : cnt0_q + 8'd1;
            cnt1_q    <= (cnt1_q == LAST1) ? 8'd0 : cnt1_q + 8'd1;
            cnt2_q    <= (cnt2_q == LAST2) ? 8'd0 : cnt2_q + 8'd1;
        end
    end

    assign clkout0  = clkout0_q;
    assign clkout1  = clkout1_q;
    assign clkout2  = clkout2_q;
    assign pll_lock = lock_q;

endmodule

// File: tb/tb_pll0_clkgen.sv
// tb/tb_pll0_clkgen.sv - scoreboard testbench for pll0_clkgen
`timescale 1ns/100ps
module tb_pll0_clkgen;

    logic clk_tb = 1'b0;
    logic rst_n  = 1'b0;
    logic grs_n  = 1'b1;
    logic clkin1 = 1'b0;
    logic clkout0;
    logic clkout1;
    logic clkout2;
    logic pll_lock;

    int cyc        = 0;
    int passed     = 0;
    int total      = 0;
    int phase      = 0;
    int cur_period = 0;

    // Expected {pll_lock, clkout2, clkout1, clkout0} at a given sample cycle
    typedef struct {
        int         at;
        logic [3:0] val;
        logic [3:0] mask;
        string      name;
    } exp_t;

    exp_t sbq[$];

    pll0_clkgen dut (
        .clk_tb   (clk_tb),
        .rst_n    (rst_n),
        .grs_n    (grs_n),
        .clkin1   (clkin1),
        .clkout0  (clkout0),
        .clkout1  (clkout1),
        .clkout2  (clkout2),
        .pll_lock (pll_lock)
    );

    always #1 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    function automatic void expect_at(input int at, input logic [3:0] val,
                                      input logic [3:0] mask, input string name);
        exp_t e;
        e.at   = at;
        e.val  = val;
        e.mask = mask;
        e.name = name;
        sbq.push_back(e);
    endfunction

    // Ideal divided-clock sequence starting at the first coincident rising edge
    function automatic void push_div(input int start, input int n, input string name);
        logic [3:0] v;
        for (int k = 0; k < n; k++) begin
            v = {1'b1, 1'((k % 10) < 5), 1'((k % 5) < 3), 1'((k % 4) < 2)};
            expect_at(start + k, v, 4'hF, name);
        end
    endfunction

    // One negedge step of the reference: high for 5 cycles, period cur_period, 0 = stopped
    task automatic ref_step(output bit rose);
        rose = 1'b0;
        if (cur_period == 0) begin
            clkin1 = 1'b0;
            phase  = 0;
        end else begin
            rose   = (phase == 0);
            clkin1 = (phase < 5);
            phase++;
            if (phase >= cur_period) phase = 0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        bit         rose;
        cur_period = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_tb);
            if (k < 20) expect_at(cyc, 4'b0000, 4'hF, "reset_hold");
            else        expect_at(cyc, 4'b0000, 4'hF, "reset_idle");
            obs = {pll_lock, clkout2, clkout1, clkout0};
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    total++;
                    if ((obs & sbq[i].mask) !== (sbq[i].val & sbq[i].mask))
                        $display("FAIL %s @%0d: got %b required %b (mask %b)", sbq[i].name, cyc, obs, sbq[i].val, sbq[i].mask);
                    else passed++;
                    sbq.delete(i);
                end
            end
            if (k == 19) rst_n = 1'b1;
            ref_step(rose);
        end
        while (sbq.size() > 0) begin
            total++;
            $display("FAIL %s: not sampled, due at cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
    endtask

    task automatic test_lock_and_divide();
        logic [3:0] obs;
        bit         rose;
        int         nr = 0;
        int         lock_rises = 0;
        int         lock_falls = 0;
        logic       prev_lock = 1'b0;
        cur_period = 10;
        phase      = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_tb);
            obs = {pll_lock, clkout2, clkout1, clkout0};
            if (pll_lock === 1'b1 && prev_lock === 1'b0) lock_rises++;
            if (pll_lock === 1'b0 && prev_lock === 1'b1) lock_falls++;
            prev_lock = pll_lock;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    total++;
                    if ((obs & sbq[i].mask) !== (sbq[i].val & sbq[i].mask))
                        $display("FAIL %s @%0d: got %b required %b (mask %b)", sbq[i].name, cyc, obs, sbq[i].val, sbq[i].mask);
                    else passed++;
                    sbq.delete(i);
                end
            end
            ref_step(rose);
            if (rose) begin
                nr++;
                if (nr < 9) begin
                    expect_at(cyc + 4, 4'b0000, 4'hF, "pre_lock");
                end else if (nr == 9) begin
                    expect_at(cyc + 3, 4'b0000, 4'hF, "lock_minus1");
                    expect_at(cyc + 4, 4'b1000, 4'hF, "lock_rise");
                    push_div(cyc + 5, 60, "div_pattern");
                end
            end
        end
        while (sbq.size() > 0) begin
            total++;
            $display("FAIL %s: not sampled, due at cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
        total++;
        if (lock_rises !== 1) $display("FAIL lock_pulse_count: got %0d required 1", lock_rises);
        else passed++;
        total++;
        if (lock_falls !== 0) $display("FAIL lock_dropped: got %0d falls required 0", lock_falls);
        else passed++;
    endtask

    task automatic test_bad_period();
        logic [3:0] obs;
        bit         rose;
        int         nr = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_tb);
            obs = {pll_lock, clkout2, clkout1, clkout0};
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    total++;
                    if ((obs & sbq[i].mask) !== (sbq[i].val & sbq[i].mask))
                        $display("FAIL %s @%0d: got %b required %b (mask %b)", sbq[i].name, cyc, obs, sbq[i].val, sbq[i].mask);
                    else passed++;
                    sbq.delete(i);
                end
            end
            ref_step(rose);
            if (rose) begin
                nr++;
                if (nr == 1) begin
                    cur_period = 13;
                end else if (nr == 2) begin
                    cur_period = 10;
                    expect_at(cyc + 3, 4'b1000, 4'b1000, "pre_drop");
                    expect_at(cyc + 4, 4'b0000, 4'b1000, "bad_drop");
                    expect_at(cyc + 5, 4'b0000, 4'hF, "bad_outs_low");
                end else if (nr < 10) begin
                    expect_at(cyc + 4, 4'b0000, 4'hF, "relock_wait");
                end else if (nr == 10) begin
                    expect_at(cyc + 4, 4'b1000, 4'hF, "relock_rise");
                    push_div(cyc + 5, 30, "relock_div");
                end
            end
        end
        while (sbq.size() > 0) begin
            total++;
            $display("FAIL %s: not sampled, due at cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
    endtask

    task automatic test_timeout();
        logic [3:0] obs;
        bit         rose;
        bit         stopped = 1'b0;
        int         c_last = 0;
        int         nr = 0;
        for (int k = 0; k < 220; k++) begin
            @(negedge clk_tb);
            obs = {pll_lock, clkout2, clkout1, clkout0};
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    total++;
                    if ((obs & sbq[i].mask) !== (sbq[i].val & sbq[i].mask))
                        $display("FAIL %s @%0d: got %b required %b (mask %b)", sbq[i].name, cyc, obs, sbq[i].val, sbq[i].mask);
                    else passed++;
                    sbq.delete(i);
                end
            end
            if (stopped && cur_period == 0 && cyc == c_last + 60) begin
                cur_period = 10;
                phase      = 0;
            end
            ref_step(rose);
            if (rose && !stopped) begin
                stopped    = 1'b1;
                c_last     = cyc;
                cur_period = 0;
                expect_at(cyc + 24, 4'b1000, 4'b1000, "pre_timeout");
                expect_at(cyc + 25, 4'b0000, 4'b1000, "timeout_drop");
                expect_at(cyc + 26, 4'b0000, 4'hF, "timeout_outs_low");
            end else if (rose) begin
                nr++;
                if (nr < 9) expect_at(cyc + 4, 4'b0000, 4'hF, "timeout_relock_wait");
                else if (nr == 9) expect_at(cyc + 4, 4'b1000, 4'hF, "timeout_relock");
            end
        end
        while (sbq.size() > 0) begin
            total++;
            $display("FAIL %s: not sampled, due at cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
    endtask

    task automatic test_async_reset(input bit use_grs);
        logic [3:0] obs;
        bit         rose;
        bit         found = 1'b0;
        int         nr = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_tb);
            ref_step(rose);
            if (clkout0 === 1'b1) found = 1'b1;
        end
        total++;
        if (!(found && pll_lock === 1'b1))
            $display("FAIL prelock_grs%0d: lock=%b clkout0=%b required 1/1", use_grs, pll_lock, clkout0);
        else passed++;
        #0.3;
        if (use_grs) grs_n = 1'b0;
        else         rst_n = 1'b0;
        cur_period = 0;
        clkin1     = 1'b0;
        #0.2;
        obs = {pll_lock, clkout2, clkout1, clkout0};
        total++;
        if (obs !== 4'b0000) $display("FAIL async_clear_grs%0d: got %b required 0000", use_grs, obs);
        else passed++;
        repeat (5) @(negedge clk_tb);
        obs = {pll_lock, clkout2, clkout1, clkout0};
        total++;
        if (obs !== 4'b0000) $display("FAIL reset_held_grs%0d: got %b required 0000", use_grs, obs);
        else passed++;
        if (use_grs) grs_n = 1'b1;
        else         rst_n = 1'b1;
        cur_period = 10;
        phase      = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk_tb);
            obs = {pll_lock, clkout2, clkout1, clkout0};
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    total++;
                    if ((obs & sbq[i].mask) !== (sbq[i].val & sbq[i].mask))
                        $display("FAIL %s @%0d: got %b required %b (mask %b)", sbq[i].name, cyc, obs, sbq[i].val, sbq[i].mask);
                    else passed++;
                    sbq.delete(i);
                end
            end
            ref_step(rose);
            if (rose) begin
                nr++;
                if (nr < 9) begin
                    expect_at(cyc + 4, 4'b0000, 4'hF, "rerun_wait");
                end else if (nr == 9) begin
                    expect_at(cyc + 3, 4'b0000, 4'hF, "rerun_minus1");
                    expect_at(cyc + 4, 4'b1000, 4'hF, "rerun_lock");
                    push_div(cyc + 5, 20, "rerun_div");
                end
            end
        end
        while (sbq.size() > 0) begin
            total++;
            $display("FAIL %s: not sampled, due at cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_divide();
        test_bad_period();
        test_timeout();
        test_async_reset(1'b0);
        test_async_reset(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
